// File: rtl/sm4_rk_order_buffer.sv
// SM4 round-key store: captures rk0..rk31 from the key expansion and replays
// them forward (encrypt) or reverse (decrypt) to the round datapath.
module sm4_rk_order_buffer #(
    parameter int width_p = 32,
    parameter int depth_p = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       clear_i,
    input  logic                       wr_v_i,
    input  logic [width_p-1:0]         wr_data_i,
    output logic                       wr_ready_o,
    output logic                       full_o,
    input  logic                       rd_start_i,
    input  logic                       rd_mode_i,
    output logic                       rd_v_o,
    output logic [width_p-1:0]         rd_data_o,
    output logic [$clog2(depth_p)-1:0] rd_idx_o,
    input  logic                       rd_ready_i,
    output logic                       rd_done_o
);

    localparam int ptr_w = $clog2(depth_p);
    localparam logic [ptr_w-1:0] last_c = ptr_w'(depth_p - 1);

    typedef enum logic [1:0] {
        LOAD,
        HOLD,
        READ
    } state_t;

    state_t state, state_next;

    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   rd_cnt;
    logic               mode;
    logic [width_p-1:0] mem [depth_p];

    logic wr_hs;
    logic rd_hs;

    assign wr_hs = (state == LOAD) && wr_v_i && !clear_i;
    assign rd_hs = (state == READ) && rd_ready_i && !clear_i;

    assign wr_ready_o = (state == LOAD);
    assign full_o     = (state != LOAD);
    assign rd_v_o     = (state == READ);
    assign rd_data_o  = mem[rd_ptr];
    assign rd_idx_o   = rd_cnt;
    // An aborted pass never reaches its final handshake, so no done pulse.
    assign rd_done_o  = rd_hs && (rd_cnt == last_c);

    always_comb begin
        state_next = state;
        if (clear_i) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (wr_hs && (wr_ptr == last_c)) state_next = HOLD;
                HOLD:    if (rd_start_i) state_next = READ;
                READ:    if (rd_hs && (rd_cnt == last_c)) state_next = HOLD;
                default: state_next = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state  <= LOAD;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_cnt <= '0;
            mode   <= 1'b0;
        end else begin
            state <= state_next;
            if (clear_i) begin
                wr_ptr <= '0;
                rd_cnt <= '0;
            end else begin
                if (wr_hs) wr_ptr <= wr_ptr + ptr_w'(1);
                if ((state == HOLD) && rd_start_i) begin
                    mode   <= rd_mode_i;
                    rd_ptr <= rd_mode_i ? last_c : '0;
                    rd_cnt <= '0;
                end else if (rd_hs) begin
                    rd_cnt <= rd_cnt + ptr_w'(1);
                    rd_ptr <= mode ? (rd_ptr - ptr_w'(1)) : (rd_ptr + ptr_w'(1));
                end
            end
        end
    end

    // Key storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_hs) mem[wr_ptr] <= wr_data_i;
    end

endmodule

// File: tb/tb_sm4_rk_order_buffer.sv
// Directed bench for sm4_rk_order_buffer: load, forward/reverse replay,
// backpressure, illegal requests, clear and asynchronous reset.
module tb_sm4_rk_order_buffer;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        clear_i;
    logic        wr_v_i;
    logic [31:0] wr_data_i;
    logic        wr_ready_o;
    logic        full_o;
    logic        rd_start_i;
    logic        rd_mode_i;
    logic        rd_v_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_idx_o;
    logic        rd_ready_i;
    logic        rd_done_o;

    int total = 0;
    int bad   = 0;

    sm4_rk_order_buffer #(.width_p(32), .depth_p(32)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .clear_i    (clear_i),
        .wr_v_i     (wr_v_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .full_o     (full_o),
        .rd_start_i (rd_start_i),
        .rd_mode_i  (rd_mode_i),
        .rd_v_o     (rd_v_o),
        .rd_data_o  (rd_data_o),
        .rd_idx_o   (rd_idx_o),
        .rd_ready_i (rd_ready_i),
        .rd_done_o  (rd_done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_keys(input logic [31:0] base, input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            @(negedge clk);
            wr_v_i    = 1'b1;
            wr_data_i = 32'(base + 32'(i));
            #1 chk("wr_ready_in_load", 32'(wr_ready_o), 32'd1);
        end
        @(negedge clk);
        wr_v_i    = 1'b0;
        wr_data_i = '0;
        #1;
    endtask

    // One full pass; rd_start_i is re-asserted with the opposite mode at beat 3.
    task automatic run_pass(input logic m, input logic [31:0] base, input bit rnd);
        int beat = 0;
        int cyc  = 0;
        int dcnt = 0;
        @(negedge clk);
        rd_start_i = 1'b1;
        rd_mode_i  = m;
        #1 chk("rd_v_in_hold", 32'(rd_v_o), 32'd0);
        @(negedge clk);
        rd_start_i = 1'b0;
        while (beat < 32 && cyc < 400) begin
            rd_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_start_i = (beat == 3);
            rd_mode_i  = ~m;
            #1;
            chk("rd_v", 32'(rd_v_o), 32'd1);
            chk("rd_idx", 32'(rd_idx_o), 32'(beat));
            chk("rd_data", rd_data_o, m ? 32'(base + 32'(31 - beat)) : 32'(base + 32'(beat)));
            chk("rd_done", 32'(rd_done_o), 32'(rd_ready_i && beat == 31));
            if (rd_done_o) dcnt++;
            if (rd_ready_i) beat++;
            cyc++;
            @(negedge clk);
        end
        rd_start_i = 1'b0;
        rd_ready_i = 1'b0;
        #1;
        chk("pass_beats", 32'(beat), 32'd32);
        chk("pass_done_count", 32'(dcnt), 32'd1);
        chk("rd_v_after_pass", 32'(rd_v_o), 32'd0);
        chk("full_after_pass", 32'(full_o), 32'd1);
    endtask

    initial begin
        reset_ni   = 1'b0;
        clear_i    = 1'b0;
        wr_v_i     = 1'b0;
        wr_data_i  = '0;
        rd_start_i = 1'b0;
        rd_mode_i  = 1'b0;
        rd_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr_ready", 32'(wr_ready_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_rd_v", 32'(rd_v_o), 32'd0);
        chk("rst_rd_done", 32'(rd_done_o), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;

        // Load then reverse pass.
        write_keys(32'h1000_0000, 0, 32);
        chk("load_wr_ready", 32'(wr_ready_o), 32'd0);
        chk("load_full", 32'(full_o), 32'd1);

        // Write attempt in HOLD must be ignored.
        @(negedge clk);
        wr_v_i    = 1'b1;
        wr_data_i = 32'hDEAD_BEEF;
        #1 chk("hold_wr_ready", 32'(wr_ready_o), 32'd0);
        @(negedge clk);
        wr_v_i = 1'b0;
        #1 chk("hold_full", 32'(full_o), 32'd1);

        run_pass(1'b1, 32'h1000_0000, 1'b0);
        run_pass(1'b0, 32'h1000_0000, 1'b0);
        run_pass(1'b1, 32'h1000_0000, 1'b1);

        // Clear on beat 5 coinciding with a handshake and rd_start_i.
        @(negedge clk);
        rd_start_i = 1'b1;
        rd_mode_i  = 1'b1;
        @(negedge clk);
        rd_start_i = 1'b0;
        rd_ready_i = 1'b1;
        for (int b = 0; b < 5; b++) begin
            #1 chk("clr_pre_data", rd_data_o, 32'(32'h1000_001F - 32'(b)));
            @(negedge clk);
        end
        clear_i    = 1'b1;
        rd_start_i = 1'b1;
        rd_mode_i  = 1'b0;
        #1;
        chk("clr_idx", 32'(rd_idx_o), 32'd5);
        chk("clr_done_same", 32'(rd_done_o), 32'd0);
        @(negedge clk);
        clear_i    = 1'b0;
        rd_start_i = 1'b0;
        rd_ready_i = 1'b0;
        #1;
        chk("clr_rd_v", 32'(rd_v_o), 32'd0);
        chk("clr_full", 32'(full_o), 32'd0);
        chk("clr_wr_ready", 32'(wr_ready_o), 32'd1);
        chk("clr_done_next", 32'(rd_done_o), 32'd0);

        // Reload; rd_start_i part-way through LOAD must be ignored.
        write_keys(32'h2000_0000, 0, 10);
        @(negedge clk);
        rd_start_i = 1'b1;
        rd_mode_i  = 1'b1;
        @(negedge clk);
        rd_start_i = 1'b0;
        #1;
        chk("load_start_rd_v", 32'(rd_v_o), 32'd0);
        chk("load_start_wr_ready", 32'(wr_ready_o), 32'd1);
        write_keys(32'h2000_0000, 10, 22);
        chk("reload_full", 32'(full_o), 32'd1);
        run_pass(1'b0, 32'h2000_0000, 1'b0);

        // Asynchronous reset after 17 writes.
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        write_keys(32'h3000_0000, 0, 17);
        #2 reset_ni = 1'b0;
        #1;
        chk("arst_load_wr_ready", 32'(wr_ready_o), 32'd1);
        chk("arst_load_full", 32'(full_o), 32'd0);
        chk("arst_load_rd_v", 32'(rd_v_o), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
        write_keys(32'h4000_0000, 0, 31);
        chk("arst_31_full", 32'(full_o), 32'd0);
        write_keys(32'h4000_0000, 31, 1);
        chk("arst_32_full", 32'(full_o), 32'd1);
        run_pass(1'b1, 32'h4000_0000, 1'b0);

        // Asynchronous reset in READ takes effect between edges.
        @(negedge clk);
        rd_start_i = 1'b1;
        rd_mode_i  = 1'b0;
        @(negedge clk);
        rd_start_i = 1'b0;
        #1 chk("arst_read_rd_v_before", 32'(rd_v_o), 32'd1);
        #2 reset_ni = 1'b0;
        #1;
        chk("arst_read_rd_v", 32'(rd_v_o), 32'd0);
        chk("arst_read_full", 32'(full_o), 32'd0);
        chk("arst_read_wr_ready", 32'(wr_ready_o), 32'd1);
        @(negedge clk);
        reset_ni = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm4_rk_order_buffer.md
Name: sm4_rk_order_buffer

Overview:
- Round-key store between the SM4 key expansion and the round datapath.
- Captures the 32 round keys rk0..rk31 in generation order from the key-expansion writer.
- Replays them to the round datapath in one of two orders:
  - forward (rk0 first) for encryption;
  - reverse (rk31 first) for decryption.
- Decryption is therefore the same round function fed from the other end of the key sequence.

Parameters:
- width_p, 32, round-key width in bits.
- depth_p, 32, number of round keys stored. Must be a power of two; ptr width is $clog2(depth_p).

Ports:
- clk_i  in  1  clock; all flops rise-edge.
- reset_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush; returns block to LOAD, key count 0.
- wr_v_i  in  1  writer valid.
- wr_data_i  in  width_p  round key being written.
- wr_ready_o  out  1  writer ready; high only in LOAD.
- full_o  out  1  all depth_p keys held; high in HOLD and READ.
- rd_start_i  in  1  start a replay pass; sampled only in HOLD.
- rd_mode_i  in  1  replay order, sampled with rd_start_i: 0 = forward, 1 = reverse (decrypt).
- rd_v_o  out  1  read valid.
- rd_data_o  out  width_p  key at current read pointer.
- rd_idx_o  out  $clog2(depth_p)  round number of the current beat, 0..depth_p-1, independent of mode.
- rd_ready_i  in  1  reader ready.
- rd_done_o  out  1  one-cycle pulse on the cycle the last beat of a pass handshakes.

Behaviour:
- Reset (reset_ni=0, asynchronous):
  - state=LOAD, wr_ptr=0, rd_ptr=0, rd_cnt=0, mode=0.
  - wr_ready_o=1 (LOAD). full_o, rd_v_o and rd_done_o are 0.
  - rd_data_o is don't-care.
  - Key storage is not reset.
- Handshakes: a transfer occurs on a cycle with v=1 and ready=1 at the rising edge.
  - rd_v_o and rd_data_o stay stable while rd_v_o=1 and rd_ready_i=0.
- LOAD:
  - wr_ready_o=1. Each write handshake stores wr_data_i at mem[wr_ptr], then wr_ptr++.
  - The write with wr_ptr=depth_p-1 moves to HOLD next cycle; wr_ptr wraps to 0.
  - rd_start_i is ignored.
- HOLD:
  - wr_ready_o=0 and full_o=1. Writes are ignored and memory is unchanged.
  - rd_start_i=1 moves to READ next cycle and latches mode=rd_mode_i.
  - It sets rd_ptr = depth_p-1 if mode=1, else 0, and rd_cnt=0.
- READ:
  - rd_v_o=1 from the first cycle in READ. Latency from rd_start_i to rd_v_o is 1 cycle.
  - rd_data_o = mem[rd_ptr], a combinational read of the storage array. rd_idx_o = rd_cnt.
  - On each read handshake, rd_cnt++. rd_ptr moves +1 (forward) or -1 (reverse), modulo depth_p.
  - Handshake with rd_cnt=depth_p-1: rd_done_o=1 that cycle; next state HOLD; rd_v_o=0 the following cycle.
  - rd_start_i and rd_mode_i are ignored while in READ.
- Re-reads: after a pass the keys are retained in HOLD. Any number of further passes in either order are allowed without reloading.
- clear_i:
  - From any state: next cycle state=LOAD, wr_ptr=0, rd_cnt=0, rd_v_o=0, full_o=0.
  - No rd_done_o pulse is produced by an aborted pass.
  - clear_i has priority over rd_start_i and over any handshake in the same cycle. A write that handshakes in that cycle is discarded.
- rd_done_o is combinational from the final handshake. All other outputs are from registered state.

Test Plan:
- Load and reverse pass: reset, write 0x1000_0000+i for i=0..31 back to back.
  - wr_ready_o drops and full_o=1 the cycle after the 32nd write.
  - Then rd_start_i=1 with rd_mode_i=1 and rd_ready_i held 1.
  - rd_v_o rises 1 cycle later. Data is 0x1000_001F down to 0x1000_0000 with rd_idx_o 0..31.
  - rd_done_o pulses exactly once, with the 0x1000_0000 beat.
- Forward re-read: from the HOLD state left by the previous scenario, rd_start_i with rd_mode_i=0.
  - Data is 0x1000_0000..0x1000_001F.
  - The stored keys are unchanged by the previous pass.
- Backpressure: reverse pass with rd_ready_i toggling pseudo-randomly.
  - rd_data_o and rd_idx_o are held stable while rd_ready_i=0.
  - Exactly 32 beats are delivered in order with no duplicates.
- Illegal requests:
  - wr_v_i=1 with data 0xDEAD_BEEF in HOLD is ignored.
  - rd_start_i in LOAD after 10 writes produces no rd_v_o.
  - rd_start_i with rd_mode_i=0 mid-pass does not change the current reverse ordering.
- Clear mid-pass: assert clear_i on beat 5 of a pass, in the same cycle as a handshake and rd_start_i.
  - Next cycle: rd_v_o=0, full_o=0, wr_ready_o=1, no rd_done_o.
  - A reload of 32 new keys followed by a pass returns only the new keys.
- Async reset mid-load: drop reset_ni between clock edges after 17 writes.
  - Outputs reach reset values immediately.
  - After release, 32 further writes are needed before full_o=1.
